// File: rtl/spi_matrix_host_pkg.sv
// Shared constants and FSM state type for the SPI matrix host.
package spi_matrix_host_pkg;

   localparam int unsigned DefaultWordW = 32;
   // CPOL=0, CPHA=0: sclk idles low, sample on rise, launch on fall
   localparam int unsigned SpiMode = 0;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StLoad,
      StShift,
      StHold
   } state_e;

endpackage

// File: rtl/spi_matrix_host_if.sv
// Control, stream and SPI pin bundle of the SPI matrix host.
interface spi_matrix_host_if
   import spi_matrix_host_pkg::*;
#(
   parameter int unsigned WORD_W = DefaultWordW,
   parameter int unsigned LEN_W  = 16
);
   logic              start;
   logic [LEN_W-1:0]  frame_len;
   logic              rx_only;
   logic [WORD_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [WORD_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic              done;
   logic              sclk;
   logic              mosi;
   logic              miso;
   logic              cs_n;

   // Host side (the SPI master itself)
   modport master (
      input  start, frame_len, rx_only, tx_data, tx_valid, miso,
      output tx_ready, rx_data, rx_valid, busy, done, sclk, mosi, cs_n
   );

   // User / board side driving the host
   modport slave (
      output start, frame_len, rx_only, tx_data, tx_valid, miso,
      input  tx_ready, rx_data, rx_valid, busy, done, sclk, mosi, cs_n
   );
endinterface

// File: rtl/spi_matrix_host_sclk_gen.sv
// SCLK generator: CLK_DIV clk cycles per half period, strobes flag the cycle before each edge.
module spi_matrix_host_sclk_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);
   localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CntW-1:0] cnt_q;
   logic            sclk_q;
   logic            last;

   assign last = (cnt_q == CntW'(CLK_DIV - 1));
   assign rise = en & last & ~sclk_q;
   assign fall = en & last & sclk_q;
   assign sclk = sclk_q;

   // Half-period counter; disabling snaps sclk low and restarts the low phase
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else if (last) begin
         cnt_q  <= '0;
         sclk_q <= ~sclk_q;
      end else begin
         cnt_q  <= cnt_q + CntW'(1);
      end
   end
endmodule

// File: rtl/spi_matrix_host.sv
// SPI mode-0 master streaming WORD_W-bit words MSB first, one frame per cs_n assertion.
module spi_matrix_host
   import spi_matrix_host_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned WORD_W  = DefaultWordW,
   parameter int unsigned LEN_W   = 16,
   parameter int unsigned CS_GAP  = 2  // must be >= 1
) (
   input logic             clk,
   input logic             rst,
   spi_matrix_host_if.master bus
);
   localparam int unsigned BitW = $clog2(WORD_W) + 1;
   localparam int unsigned GapW = $clog2(CS_GAP + 1);

   state_e            state_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  word_cnt_q;
   logic              rx_only_q;
   logic [BitW-1:0]   bit_cnt_q;
   logic [GapW-1:0]   gap_q;
   logic [WORD_W-1:0] tx_sh_q;
   logic [WORD_W-1:0] rx_sh_q;
   logic [WORD_W-1:0] rx_data_q;
   logic              mosi_q;
   logic              cs_n_q;
   logic              busy_q;
   logic              done_q;
   logic              rx_valid_q;

   logic              sclk_lvl;
   logic              sclk_rise;
   logic              sclk_fall;
   logic              gap_last;
   logic              word_last;

   assign gap_last  = (gap_q == GapW'(CS_GAP - 1));
   assign word_last = ((word_cnt_q + LEN_W'(1)) == len_q);

   spi_matrix_host_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == StShift),
      .sclk (sclk_lvl),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   assign bus.tx_ready = (state_q == StLoad) && !rx_only_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sclk     = sclk_lvl;
   assign bus.mosi     = mosi_q;
   assign bus.cs_n     = cs_n_q;

   // Frame FSM with shift registers, bit/word counters and registered pin outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         len_q      <= '0;
         word_cnt_q <= '0;
         rx_only_q  <= 1'b0;
         bit_cnt_q  <= '0;
         gap_q      <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  if (bus.frame_len != '0) begin
                     len_q      <= bus.frame_len;
                     rx_only_q  <= bus.rx_only;
                     word_cnt_q <= '0;
                     gap_q      <= '0;
                     busy_q     <= 1'b1;
                     cs_n_q     <= 1'b0;
                     state_q    <= StSetup;
                  end else begin
                     // Empty frame completes without touching the bus
                     done_q <= 1'b1;
                  end
               end
            end
            StSetup: begin
               if (gap_last) begin
                  gap_q   <= '0;
                  state_q <= StLoad;
               end else begin
                  gap_q <= gap_q + GapW'(1);
               end
            end
            StLoad: begin
               bit_cnt_q <= '0;
               if (rx_only_q) begin
                  tx_sh_q <= '0;
                  mosi_q  <= 1'b0;
                  state_q <= StShift;
               end else if (bus.tx_valid) begin
                  tx_sh_q <= bus.tx_data;
                  mosi_q  <= bus.tx_data[WORD_W-1];
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (sclk_rise) begin
                  rx_sh_q <= {rx_sh_q[WORD_W-2:0], bus.miso};
               end
               if (sclk_fall) begin
                  tx_sh_q <= tx_sh_q << 1;
                  mosi_q  <= tx_sh_q[WORD_W-2];
                  if (bit_cnt_q == BitW'(WORD_W - 1)) begin
                     bit_cnt_q  <= '0;
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= rx_sh_q;
                     word_cnt_q <= word_cnt_q + LEN_W'(1);
                     state_q    <= word_last ? StHold : StLoad;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BitW'(1);
                  end
               end
            end
            StHold: begin
               if (gap_last) begin
                  gap_q   <= '0;
                  cs_n_q  <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  gap_q <= gap_q + GapW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_matrix_host.sv
// Scoreboard bench for spi_matrix_host: directed frames, loopback and slave-model MISO.
module tb_spi_matrix_host;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   spi_matrix_host_if #(.WORD_W(32), .LEN_W(16)) bus ();

   spi_matrix_host #(
      .CLK_DIV (2),
      .WORD_W  (32),
      .LEN_W   (16),
      .CS_GAP  (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_rx[$];
   logic [31:0] exp_mosi[$];
   logic [31:0] slv_words[$];
   logic [31:0] txw[8];
   logic [31:0] rxw[8];

   logic [31:0] slv_sh = '0;
   int          slv_bits = 0;
   logic [31:0] mon_sh = '0;
   int          mon_bits = 0;
   int          rises = 0;
   int          cs_low = 0;
   int          done_cnt = 0;
   int          rxv_cnt = 0;
   bit          saw_ready = 1'b0;
   bit          loop_mode = 1'b1;
   bit          aborted = 1'b0;

   assign bus.miso = loop_mode ? bus.mosi : slv_sh[31];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endtask

   // Cycle-level monitors plus the rx scoreboard
   always @(negedge clk) begin
      if (bus.cs_n === 1'b0) cs_low++;
      if (bus.done === 1'b1) done_cnt++;
      if (bus.tx_ready === 1'b1) saw_ready = 1'b1;
      if (bus.rx_valid === 1'b1) begin
         rxv_cnt++;
         if (exp_rx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got %h expected no word", bus.rx_data);
         end else begin
            chk("rx_word", bus.rx_data, exp_rx.pop_front());
         end
      end
   end

   // MOSI capture on sclk rise, compared word by word
   always @(posedge bus.sclk) begin
      rises++;
      slv_bits++;
      mon_sh = {mon_sh[30:0], bus.mosi};
      mon_bits++;
      if (mon_bits == 32) begin
         mon_bits = 0;
         if (exp_mosi.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mosi_unexpected: got %h expected no word", mon_sh);
         end else begin
            chk("mosi_word", mon_sh, exp_mosi.pop_front());
         end
      end
   end

   // Slave model: first word presented on cs_n fall
   always @(negedge bus.cs_n) begin
      slv_bits = 0;
      if (slv_words.size() != 0) slv_sh = slv_words.pop_front();
      else slv_sh = '0;
   end

   // Slave model: shift on sclk fall, next word after 32 bits
   always @(negedge bus.sclk) begin
      if (slv_bits == 32) begin
         slv_bits = 0;
         if (slv_words.size() != 0) slv_sh = slv_words.pop_front();
         else slv_sh = '0;
      end else begin
         slv_sh = {slv_sh[30:0], 1'b0};
      end
   end

   task automatic do_frame(input int len, input bit rxo, input int stall_at, input bit inj);
      int guard;
      for (int w = 0; w < len; w++) begin
         exp_mosi.push_back(rxo ? 32'h0 : txw[w]);
         exp_rx.push_back(rxw[w]);
      end
      @(negedge clk);
      bus.frame_len = 16'(len);
      bus.rx_only   = rxo;
      bus.start     = 1'b1;
      bus.tx_valid  = rxo;
      bus.tx_data   = 32'h5A5A_F00F;
      @(negedge clk);
      bus.start = 1'b0;
      if (!rxo) begin
         for (int w = 0; w < len; w++) begin
            if (w == stall_at) begin
               bus.tx_valid = 1'b0;
               guard = 0;
               while (bus.tx_ready !== 1'b1 && !aborted && guard < 2000) begin
                  @(negedge clk);
                  guard++;
               end
               if (aborted) return;
               if (guard >= 2000) begin
                  timeout("stall_wait");
                  return;
               end
               for (int s = 0; s < 10; s++) begin
                  chk("stall_sclk", 32'(bus.sclk), 32'h0);
                  chk("stall_cs_n", 32'(bus.cs_n), 32'h0);
                  @(negedge clk);
               end
            end
            bus.tx_data  = txw[w];
            bus.tx_valid = 1'b1;
            guard = 0;
            while (bus.tx_ready !== 1'b1 && !aborted && guard < 2000) begin
               @(negedge clk);
               guard++;
            end
            if (aborted) return;
            if (guard >= 2000) begin
               timeout("tx_ready_wait");
               return;
            end
            @(negedge clk);
            if (inj && w == 0) begin
               bus.frame_len = 16'd7;
               bus.start     = 1'b1;
               @(negedge clk);
               bus.start = 1'b0;
            end
         end
         bus.tx_valid = 1'b0;
      end
      guard = 0;
      while (bus.done !== 1'b1 && !aborted && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      bus.tx_valid = 1'b0;
      if (!aborted && guard >= 5000) timeout("done_wait");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.frame_len = '0;
      bus.rx_only   = 1'b0;
      bus.tx_data   = '0;
      bus.tx_valid  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", 32'(bus.cs_n), 32'h1);
      chk("rst_sclk", 32'(bus.sclk), 32'h0);
      chk("rst_mosi", 32'(bus.mosi), 32'h0);
      chk("rst_tx_ready", 32'(bus.tx_ready), 32'h0);
      chk("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_rx_data", bus.rx_data, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single word: 2 setup + 1 load + 128 shift + 2 hold cycles of cs_n low
      txw[0] = 32'hA5A5_0001;
      rxw[0] = 32'hA5A5_0001;
      rises = 0; cs_low = 0; done_cnt = 0;
      do_frame(1, 1'b0, -1, 1'b0);
      @(negedge clk);
      chk("t1_rises", rises, 32);
      chk("t1_cs_low_cycles", cs_low, 133);
      chk("t1_done_pulses", done_cnt, 1);
      chk("t1_cs_n_idle", 32'(bus.cs_n), 32'h1);
      chk("t1_busy_idle", 32'(bus.busy), 32'h0);

      // Loopback, back-to-back words, with a start pulse injected while busy
      txw[0] = 32'h0000_0001; txw[1] = 32'hFFFF_FFFF; txw[2] = 32'h8000_0000;
      rxw[0] = 32'h0000_0001; rxw[1] = 32'hFFFF_FFFF; rxw[2] = 32'h8000_0000;
      rises = 0; done_cnt = 0; rxv_cnt = 0;
      do_frame(3, 1'b0, -1, 1'b1);
      repeat (300) @(negedge clk);
      chk("t2_rx_valid_pulses", rxv_cnt, 3);
      chk("t2_rises", rises, 96);
      chk("t2_frames", done_cnt, 1);
      chk("t2_cs_n_idle", 32'(bus.cs_n), 32'h1);
      chk("t2_busy_idle", 32'(bus.busy), 32'h0);

      // Underrun before word 2: sclk and cs_n parked low, no extra edges
      txw[0] = 32'h1234_5678; txw[1] = 32'h9ABC_DEF0; txw[2] = 32'h0F1E_2D3C;
      rxw[0] = 32'h1234_5678; rxw[1] = 32'h9ABC_DEF0; rxw[2] = 32'h0F1E_2D3C;
      rises = 0;
      do_frame(3, 1'b0, 1, 1'b0);
      @(negedge clk);
      chk("t3_rises", rises, 96);
      chk("t3_rx_queue_empty", exp_rx.size(), 0);

      // Receive-only: MOSI stays zero, no tx handshake, slave data captured
      loop_mode = 1'b0;
      slv_words = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_F00D, 32'h7654_3210};
      rxw[0] = 32'hDEAD_BEEF; rxw[1] = 32'hCAFE_F00D;
      rxw[2] = 32'h0BAD_F00D; rxw[3] = 32'h7654_3210;
      saw_ready = 1'b0; rxv_cnt = 0;
      do_frame(4, 1'b1, -1, 1'b0);
      @(negedge clk);
      chk("t4_tx_ready_seen", 32'(saw_ready), 32'h0);
      chk("t4_rx_valid_pulses", rxv_cnt, 4);
      loop_mode = 1'b1;

      // Empty frame: done next cycle, bus untouched
      done_cnt = 0; cs_low = 0;
      bus.frame_len = 16'd0;
      bus.rx_only   = 1'b0;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("t5_done", 32'(bus.done), 32'h1);
      chk("t5_cs_n", 32'(bus.cs_n), 32'h1);
      chk("t5_busy", 32'(bus.busy), 32'h0);
      @(negedge clk);
      chk("t5_done_single", 32'(bus.done), 32'h0);
      repeat (5) @(negedge clk);
      chk("t5_done_pulses", done_cnt, 1);
      chk("t5_cs_low_cycles", cs_low, 0);

      // Reset at bit 17 of word 2, then a clean frame
      txw[0] = 32'h1357_9BDF; txw[1] = 32'h2468_ACE0; txw[2] = 32'hFEDC_BA98;
      rxw[0] = 32'h1357_9BDF; rxw[1] = 32'h2468_ACE0; rxw[2] = 32'hFEDC_BA98;
      rises = 0; aborted = 1'b0;
      fork
         do_frame(3, 1'b0, -1, 1'b0);
         begin : rst_branch
            int g;
            g = 0;
            while (rises < 49 && g < 3000) begin
               @(negedge clk);
               g++;
            end
            if (g >= 3000) timeout("t6_bit17_wait");
            rst     = 1'b1;
            aborted = 1'b1;
            @(negedge clk);
            chk("t6_cs_n", 32'(bus.cs_n), 32'h1);
            chk("t6_sclk", 32'(bus.sclk), 32'h0);
            chk("t6_busy", 32'(bus.busy), 32'h0);
            chk("t6_mosi", 32'(bus.mosi), 32'h0);
            chk("t6_tx_ready", 32'(bus.tx_ready), 32'h0);
            exp_rx.delete();
            exp_mosi.delete();
            mon_bits = 0;
            rst = 1'b0;
         end
      join
      bus.tx_valid = 1'b0;
      aborted = 1'b0;
      repeat (3) @(negedge clk);
      txw[0] = 32'hC001_D00D; txw[1] = 32'h0000_FFFF;
      rxw[0] = 32'hC001_D00D; rxw[1] = 32'h0000_FFFF;
      rises = 0; rxv_cnt = 0; done_cnt = 0;
      do_frame(2, 1'b0, -1, 1'b0);
      @(negedge clk);
      chk("t6_clean_rises", rises, 64);
      chk("t6_clean_rx_pulses", rxv_cnt, 2);
      chk("t6_clean_done", done_cnt, 1);

      repeat (5) @(negedge clk);
      chk("final_rx_queue_empty", exp_rx.size(), 0);
      chk("final_mosi_queue_empty", exp_mosi.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
